// File: rtl/matvec_mul.sv
// matvec_mul: pipelined signed matrix-vector multiplier, y = K * x.
// Stage 1 registers all R*C products. Each row then goes through its own
// binary adder tree with $clog2(C) registered levels. The last level drives y.
//
// Clock-enable contract: cen=1 on a rising edge samples k/x and advances every
// stage by one step. cen=0 freezes every stage, including y. There is no
// backpressure, so one input set can be taken on every enabled cycle.
//
// Optional feature: define MATVEC_MUL_VALID_EN to add valid_in/valid_out.
// valid_in then moves through a LATENCY-deep shift register that advances with
// the datapath, so valid_out lines up with y.
module matvec_mul #(
  parameter int R   = 2,
  parameter int C   = 5,
  parameter int W_X = 3,
  parameter int W_K = 4,
  localparam int W_Y = W_X + W_K + $clog2(C)
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic                                cen,
  input  logic signed [R-1:0][C-1:0][W_K-1:0] k,
  input  logic signed [C-1:0][W_X-1:0]        x,
`ifdef MATVEC_MUL_VALID_EN
  input  logic                                valid_in,
  output logic                                valid_out,
`endif
  output logic signed [R-1:0][W_Y-1:0]        y
);

  // Number of registered adder-tree levels.
  localparam int LVLS    = $clog2(C);
  // Stages from input sampling to y: the product register plus the tree levels.
  localparam int LATENCY = LVLS + 1;

  // Element count held at tree level l.
  // Level 0 holds C products, and each later level holds ceil(previous / 2).
  function automatic int lvl_n(input int l);
    int n;
    n = C;
    for (int j = 0; j < l; j++) begin
      n = (n + 1) / 2;
    end
    return n;
  endfunction

  // Each level, row and element gets its own _d/_q pair.
  // A level only refers to the level before it through constant generate
  // indices, so every register exists only where the tree needs it.
  for (genvar l = 0; l <= LVLS; l++) begin : g_lvl
    localparam int N  = lvl_n(l);
    localparam int NP = (l == 0) ? C : lvl_n(l - 1);
    for (genvar r = 0; r < R; r++) begin : g_row
      for (genvar i = 0; i < N; i++) begin : g_el
        logic signed [W_Y-1:0] s_d;
        logic signed [W_Y-1:0] s_q;

        if (l == 0) begin : g_prod
          // Product k[r][i]*x[i]. Both operands are sign-extended to W_Y first.
          // The full W_X+W_K-bit product always fits, so nothing is lost.
          always_comb begin
            s_d = W_Y'($signed(k[r][i])) * W_Y'($signed(x[i]));
          end
        end else if (2 * i + 1 < NP) begin : g_add
          // Sum of one pair from the previous level. W_Y leaves room for the
          // largest possible sum, so this add never overflows.
          always_comb begin
            s_d = g_lvl[l-1].g_row[r].g_el[2*i].s_q
                + g_lvl[l-1].g_row[r].g_el[2*i+1].s_q;
          end
        end else begin : g_pass
          // Odd leftover element: passed to the next level unchanged.
          always_comb begin
            s_d = g_lvl[l-1].g_row[r].g_el[2*i].s_q;
          end
        end

        // Pipeline register: async clear, and it advances only on enabled edges.
        always_ff @(posedge clk or negedge rstn) begin
          if (!rstn) begin
            s_q <= '0;
          end else if (cen) begin
            s_q <= s_d;
          end
        end
      end
    end
  end

  // The single element at the last tree level of each row is that row's result.
  for (genvar r = 0; r < R; r++) begin : g_out
    assign y[r] = g_lvl[LVLS].g_row[r].g_el[0].s_q;
  end

`ifdef MATVEC_MUL_VALID_EN
  logic [LATENCY-1:0] vld_d;
  logic [LATENCY-1:0] vld_q;

  // Next state of the valid shift register: valid_in enters at bit 0.
  always_comb begin
    vld_d    = vld_q;
    vld_d[0] = valid_in;
    for (int i = 1; i < LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
    end
  end

  // Valid shift register.
  // It has the same clear and enable behaviour as the datapath stages.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_q <= '0;
    end else if (cen) begin
      vld_q <= vld_d;
    end
  end

  assign valid_out = vld_q[LATENCY-1];
`endif

endmodule

// File: tb/tb_matvec_mul.sv
// Testbench for matvec_mul with the default parameters (R=2, C=5, W_Y=10, LATENCY=4).
// The driver pushes one expected y per enabled cycle that carries a real
// vector. The monitor tags each enabled edge and follows the tags LATENCY
// edges deep:
//   tag 0 = a stage cleared by reset, so y must be 0.
//   tag 1 = a real vector, so y is compared with the next expected value.
//   tag 2 = don't care.
// On edges with cen=0 the monitor checks that y still holds its last known value.
module tb_matvec_mul;
  localparam int R   = 2;
  localparam int C   = 5;
  localparam int W_X = 3;
  localparam int W_K = 4;
  localparam int W_Y = 10;
  localparam int LAT = 4;

  typedef logic [R-1:0][C-1:0][W_K-1:0] k_t;
  typedef logic [C-1:0][W_X-1:0]        x_t;
  typedef logic [R*W_Y-1:0]             y_t;

  logic clk = 1'b0;
  logic rstn;
  logic cen;
  logic signed [R-1:0][C-1:0][W_K-1:0] k;
  logic signed [C-1:0][W_X-1:0]        x;
  logic signed [R-1:0][W_Y-1:0]        y;
`ifdef MATVEC_MUL_VALID_EN
  logic vin;
  logic vout;
`endif

  y_t   exp_q[$];
  int   tag_pipe[LAT];
  int   drv_tag;
  y_t   last_exp;
  bit   last_known;
  int   n_total;
  int   n_bad;

  // ---------------- clock / reset -----------------
  always #5 clk = ~clk;

  matvec_mul #(.R(R), .C(C), .W_X(W_X), .W_K(W_K)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .cen      (cen),
    .k        (k),
    .x        (x),
`ifdef MATVEC_MUL_VALID_EN
    .valid_in (vin),
    .valid_out(vout),
`endif
    .y        (y)
  );

`ifdef MATVEC_MUL_VALID_EN
  initial vin = 1'b0;
`endif

  // ---------------- helpers -----------------
  task automatic check_y(input y_t act, input y_t expv, input string name);
    n_total++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: y=%h expected=%h at t=%0t", name, act, expv, $time);
    end
  endtask

  task automatic check_int(input int act, input int expv, input string name);
    n_total++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d", name, act, expv);
    end
  endtask

  function automatic y_t pk(input int y0, input int y1);
    y_t res;
    res[W_Y-1:0]     = y0[W_Y-1:0];
    res[2*W_Y-1:W_Y] = y1[W_Y-1:0];
    return res;
  endfunction

  function automatic k_t k_rows(input int a, input int b);
    k_t km;
    for (int c = 0; c < C; c++) begin
      km[0][c] = a[W_K-1:0];
      km[1][c] = b[W_K-1:0];
    end
    return km;
  endfunction

  function automatic x_t x_all(input int v);
    x_t xm;
    for (int c = 0; c < C; c++) xm[c] = v[W_X-1:0];
    return xm;
  endfunction

  // Reference dot products, using plain integer arithmetic.
  function automatic y_t model(input k_t km, input x_t xm);
    y_t res;
    int acc;
    int kv;
    int xv;
    res = '0;
    for (int r = 0; r < R; r++) begin
      acc = 0;
      for (int c = 0; c < C; c++) begin
        kv  = $signed(km[r][c]);
        xv  = $signed(xm[c]);
        acc = acc + kv * xv;
      end
      res[r*W_Y +: W_Y] = acc[W_Y-1:0];
    end
    return res;
  endfunction

  // ---------------- driver tasks -----------------
  task automatic issue(input k_t kin, input x_t xin, input int tag, input y_t ev);
    @(negedge clk);
    k       = kin;
    x       = xin;
    cen     = 1'b1;
    drv_tag = tag;
    if (tag == 1) exp_q.push_back(ev);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      cen     = 1'b0;
      drv_tag = 2;
    end
  endtask

  task automatic reset_mid_stream();
    @(negedge clk);
    rstn    = 1'b0;
    cen     = 1'b1;
    drv_tag = 2;
    k       = k_rows(1, 1);
    x       = x_all(1);
    #1;
    check_y(y, '0, "rst_async");
    exp_q.delete();
    for (int i = 0; i < LAT; i++) tag_pipe[i] = 0;
    last_exp   = '0;
    last_known = 1'b1;
    @(posedge clk);
    #1;
    check_y(y, '0, "rst_over_cen");
    @(negedge clk);
    cen  = 1'b0;
    rstn = 1'b1;
  endtask

  // ---------------- monitor / scoreboard -----------------
  always @(posedge clk) begin
    y_t e;
    if (rstn === 1'b1) begin
      if (cen === 1'b1) begin
        for (int i = LAT - 1; i > 0; i--) tag_pipe[i] = tag_pipe[i-1];
        tag_pipe[0] = drv_tag;
        #1;
        if (tag_pipe[LAT-1] == 0) begin
          check_y(y, '0, "rst_flush");
          last_exp   = '0;
          last_known = 1'b1;
        end else if (tag_pipe[LAT-1] == 1) begin
          if (exp_q.size() == 0) begin
            check_int(0, 1, "exp_underflow");
            last_known = 1'b0;
          end else begin
            e = exp_q.pop_front();
            check_y(y, e, "result");
            last_exp   = e;
            last_known = 1'b1;
          end
        end else begin
          last_known = 1'b0;
        end
      end else begin
        #1;
        if (last_known) check_y(y, last_exp, "hold");
      end
    end
  end

  // ---------------- watchdog -----------------
  initial begin
    #100000;
    n_total++;
    n_bad++;
    $display("FAIL watchdog: time=%0t limit=100000", $time);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  // ---------------- stimulus -----------------
  initial begin
    k_t kr;
    k_t krand;
    x_t xrand;
    n_total    = 0;
    n_bad      = 0;
    rstn       = 1'b0;
    cen        = 1'b0;
    k          = '0;
    x          = '0;
    drv_tag    = 2;
    last_exp   = '0;
    last_known = 1'b1;
    for (int i = 0; i < LAT; i++) tag_pipe[i] = 0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    idle(2);

    // Reset test: stream ones, reset mid-stream, then ones again -> {5,5}.
    for (int i = 0; i < 6; i++) issue(k_rows(1, 1), x_all(1), 1, pk(5, 5));
    reset_mid_stream();
    for (int i = 0; i < 2; i++) issue(k_rows(1, 1), x_all(1), 1, pk(5, 5));

    // Sign test: 7 * -1 * 5 = -35.
    issue(k_rows(7, 7), x_all(-1), 1, pk(-35, -35));
    issue(k_rows(7, 7), x_all(-1), 1, pk(-35, -35));

    // Extremes: -8*-4*5 = 160 ; -8*3*5 = -120.
    issue(k_rows(-8, -8), x_all(-4), 1, pk(160, 160));
    issue(k_rows(-8, -8), x_all(3),  1, pk(-120, -120));

    // Row independence: row0 zeros, row1 = 1..5, x = 2 -> {0, 30}.
    kr = '0;
    for (int c = 0; c < C; c++) kr[1][c] = 4'(c + 1);
    issue(kr, x_all(2), 1, pk(0, 30));

    // Stall test: a 3-cycle cen=0 gap mid-stream.
    issue(k_rows(2, 2),  x_all(3),  1, pk(30, 30));
    issue(k_rows(-1, -1), x_all(1), 1, pk(-5, -5));
    issue(k_rows(1, -2), x_all(-2), 1, pk(-10, 20));
    idle(3);
    issue(k_rows(5, 5),  x_all(-3), 1, pk(-75, -75));
    issue(k_rows(0, 0),  x_all(3),  1, pk(0, 0));

    // Pipelining: 10 random back-to-back vectors against the reference model.
    for (int n = 0; n < 10; n++) begin
      for (int r = 0; r < R; r++)
        for (int c = 0; c < C; c++) krand[r][c] = 4'($urandom_range(0, 15));
      for (int c = 0; c < C; c++) xrand[c] = 3'($urandom_range(0, 7));
      issue(krand, xrand, 1, model(krand, xrand));
    end

    // Drain the pipeline with don't-care cycles, then idle.
    for (int i = 0; i < LAT; i++) issue(k_rows(0, 0), x_all(0), 2, '0);
    idle(3);
    check_int(exp_q.size(), 0, "drain_empty");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
